// File: rtl/dbg_inst_injector.sv
// dbg_inst_injector: debug command to RV32I instruction-sequence encoder feeding the fetch injection port (option macro DBG_HAZARD_NOP_EN)
module dbg_inst_injector #(
    parameter int          SCRATCH_A = 30,
    parameter int          SCRATCH_B = 31,
    parameter logic [11:0] MBOX_OFF  = 12'h7F0,
    parameter int          NOP_COUNT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_reg,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic        abort,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        busy,
    output logic        done
);
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [4:0]  RA    = 5'(SCRATCH_A);
    localparam logic [4:0]  RB    = 5'(SCRATCH_B);
    localparam logic [7:0]  NOPS  = 8'(NOP_COUNT);
    localparam logic [6:0]  OP_SW = 7'b0100011;
`ifdef DBG_HAZARD_NOP_EN
    localparam bit NOP_EN = 1'b1;
`else
    localparam bit NOP_EN = 1'b0;
`endif

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t      r_state;
    logic        r_cmd_ready;
    logic        r_valid;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_instr;
    logic [1:0]  r_op;
    logic [4:0]  r_reg;
    logic [31:0] r_addr;
    logic [31:0] r_data;
    logic [2:0]  r_step;
    logic [7:0]  r_nop;
    logic [2:0]  w_last;
    logic        w_pad;

    // Upper immediate rounded so that a following sign-extended ADDI lands on v.
    function automatic logic [19:0] hi(input logic [31:0] v);
        return 20'((v + 32'h800) >> 12);
    endfunction

    function automatic logic [31:0] lui(input logic [4:0] rd, input logic [19:0] imm);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
        return {imm, rs, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs, input logic [11:0] imm);
        return {imm, rs, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_SW};
    endfunction

    // Base instruction word for step st of a command sequence.
    function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rg,
                                        input logic [31:0] a, input logic [31:0] d, input logic [2:0] st);
        case (op)
            2'd0:    return st == 3'd0 ? lui(rg, hi(d)) : addi(rg, rg, d[11:0]);
            2'd1:    return sw(rg, 5'd0, MBOX_OFF);
            2'd2:    return st == 3'd0 ? lui(RA, hi(a)) :
                            st == 3'd1 ? addi(RA, RA, a[11:0]) :
                            st == 3'd2 ? lui(RB, hi(d)) :
                            st == 3'd3 ? addi(RB, RB, d[11:0]) : sw(RB, RA, 12'd0);
            default: return st == 3'd0 ? lui(RA, hi(a)) :
                            st == 3'd1 ? addi(RA, RA, a[11:0]) :
                            st == 3'd2 ? lw(RB, RA, 12'd0) : sw(RB, 5'd0, MBOX_OFF);
        endcase
    endfunction

    // Final base step per opcode, and whether the word just consumed needs hazard NOPs behind it.
    always_comb begin
        w_last = r_op == 2'd0 ? 3'd1 : r_op == 2'd1 ? 3'd0 : r_op == 2'd2 ? 3'd4 : 3'd3;
        w_pad  = NOP_EN && NOPS != 8'd0 && r_nop == 8'd0 && r_instr[6:0] != OP_SW;
    end

    // Sequencer: accept a command, stream its words with valid/ready, pulse done after the last one.
    always_ff @(posedge clk) begin
        r_done <= 1'b0;
        if (rst || abort) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_instr     <= NOP;
            r_step      <= 3'd0;
            r_nop       <= 8'd0;
        end else if (r_state == S_IDLE) begin
            if (r_cmd_ready && cmd_valid) begin
                r_op        <= cmd_op;
                r_reg       <= cmd_reg;
                r_addr      <= cmd_addr;
                r_data      <= cmd_data;
                r_step      <= 3'd0;
                r_nop       <= 8'd0;
                r_instr     <= enc(cmd_op, cmd_reg, cmd_addr, cmd_data, 3'd0);
                r_valid     <= 1'b1;
                r_busy      <= 1'b1;
                r_cmd_ready <= 1'b0;
                r_state     <= S_EMIT;
            end else begin
                r_cmd_ready <= 1'b1;
            end
        end else if (instr_ready) begin
            if (w_pad) begin
                r_nop   <= NOPS;
                r_instr <= NOP;
            end else if (r_nop > 8'd1) begin
                r_nop <= r_nop - 8'd1;
            end else if (r_step == w_last) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_instr <= NOP;
                r_nop   <= 8'd0;
            end else begin
                r_step  <= r_step + 3'd1;
                r_instr <= enc(r_op, r_reg, r_addr, r_data, r_step + 3'd1);
                r_nop   <= 8'd0;
            end
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign busy        = r_busy;
    assign done        = r_done;
endmodule

// File: tb/tb_dbg_inst_injector.sv
// tb_dbg_inst_injector: directed self-checking bench for dbg_inst_injector
module tb_dbg_inst_injector;
    typedef logic [31:0] wq_t[$];
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [4:0]  cmd_reg = 5'd0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        abort = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    int          checks = 0;
    int          failures = 0;

    dbg_inst_injector dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_reg(cmd_reg), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .abort(abort),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected stream: hazard NOPs (two) follow every non-store word when the option is built in.
    function automatic wq_t pad(wq_t q);
        wq_t r;
        foreach (q[i]) begin
            r.push_back(q[i]);
`ifdef DBG_HAZARD_NOP_EN
            if (q[i][6:0] != 7'b0100011) begin
                r.push_back(NOP);
                r.push_back(NOP);
            end
`endif
        end
        return r;
    endfunction

    task automatic issue(input logic [1:0] op, input logic [4:0] rg, input logic [31:0] a, input logic [31:0] d);
        cmd_op = op; cmd_reg = rg; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrreg(input logic [4:0] rg, input logic [31:0] d, input logic [31:0] w0, input logic [31:0] w1);
        wq_t q, exp;
        int  pulses = 0;
        q = {w0, w1};
        exp = pad(q);
        instr_ready = 1'b1;
        issue(2'd0, rg, 32'd0, d);
        foreach (exp[i]) begin
            checks++; if (instr_valid !== 1'b1 || instr !== exp[i]) begin failures++; $display("FAIL wrreg_x%0d_word%0d valid=%b got=%h exp=%h", rg, i, instr_valid, instr, exp[i]); end
            checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL wrreg_cmd_ready_word%0d got=%b exp=0", i, cmd_ready); end
            if (done === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL wrreg_done got done=%b valid=%b exp done=1 valid=0", done, instr_valid); end
        @(negedge clk);
        if (done === 1'b1) pulses++;
        checks++; if (pulses != 0) begin failures++; $display("FAIL wrreg_done_extra got=%0d exp=0", pulses); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wrreg_ready_after got=%b exp=1", cmd_ready); end
    endtask

    task automatic test_rdreg;
        instr_ready = 1'b1;
        issue(2'd1, 5'd10, 32'd0, 32'd0);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h7EA0_2823) begin failures++; $display("FAIL rdreg_word valid=%b got=%h exp=7ea02823", instr_valid, instr); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rdreg_busy_on got=%b exp=1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL rdreg_end got busy=%b done=%b valid=%b exp 0/1/0", busy, done, instr_valid); end
        @(negedge clk);
    endtask

    task automatic test_wrmem;
        wq_t q, exp;
        q = {32'h0000_1F37, 32'h000F_0F13, 32'h0000_0FB7, 32'h001F_8F93, 32'h01FF_2023};
        exp = pad(q);
        instr_ready = 1'b1;
        issue(2'd2, 5'd0, 32'h0000_1000, 32'h0000_0001);
        foreach (exp[i]) begin
            checks++; if (instr_valid !== 1'b1 || instr !== exp[i]) begin failures++; $display("FAIL wrmem_word%0d valid=%b got=%h exp=%h", i, instr_valid, instr, exp[i]); end
            checks++; if (cmd_ready !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL wrmem_flags_word%0d ready=%b done=%b exp 0/0", i, cmd_ready, done); end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL wrmem_done got=%b exp=1", done); end
        @(negedge clk);
    endtask

    task automatic test_rdmem_backpressure;
        wq_t q, exp;
        q = {32'h0000_0F37, 32'h800F_0F13, 32'h000F_2F83, 32'h7FF0_2823};
        exp = pad(q);
        instr_ready = 1'b1;
        issue(2'd3, 5'd0, 32'hFFFF_F800, 32'd0);
        foreach (exp[i]) begin
            checks++; if (instr_valid !== 1'b1 || instr !== exp[i]) begin failures++; $display("FAIL rdmem_word%0d valid=%b got=%h exp=%h", i, instr_valid, instr, exp[i]); end
            if (i == 1) begin
                instr_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    checks++; if (instr_valid !== 1'b1 || instr !== exp[i]) begin failures++; $display("FAIL rdmem_stall%0d valid=%b got=%h exp=%h", k, instr_valid, instr, exp[i]); end
                end
                instr_ready = 1'b1;
            end
            @(negedge clk);
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL rdmem_done got=%b exp=1", done); end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int pulses = 0;
        instr_ready = 1'b1;
        issue(2'd2, 5'd0, 32'h0000_1000, 32'h0000_0001);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_state valid=%b busy=%b done=%b exp 0/0/0", instr_valid, busy, done); end
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL abort_cmd_ready got=%b exp=1", cmd_ready); end
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin failures++; $display("FAIL abort_done_pulses got=%0d exp=0", pulses); end
        cmd_op = 2'd1; cmd_reg = 5'd10; cmd_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0; abort = 1'b0;
        checks++; if (instr_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_beats_accept valid=%b busy=%b exp 0/0", instr_valid, busy); end
        issue(2'd1, 5'd10, 32'd0, 32'd0);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h7EA0_2823) begin failures++; $display("FAIL abort_new_cmd valid=%b got=%h exp=7ea02823", instr_valid, instr); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        instr_ready = 1'b1;
        cmd_op = 2'd1; cmd_reg = 5'd1; cmd_valid = 1'b1;
        @(negedge clk);
        checks++; if (instr !== 32'h7E10_2823) begin failures++; $display("FAIL b2b_first got=%h exp=7e102823", instr); end
        cmd_reg = 5'd2;
        @(negedge clk);
        checks++; if (done !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_done_cycle done=%b ready=%b exp 1/0", done, cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1 || instr_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap ready=%b valid=%b exp 1/0", cmd_ready, instr_valid); end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h7E20_2823) begin failures++; $display("FAIL b2b_second valid=%b got=%h exp=7e202823", instr_valid, instr); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_wrreg(5'd5, 32'h1234_5FFF, 32'h1234_62B7, 32'hFFF2_8293);
        test_wrreg(5'd0, 32'h0000_0800, 32'h0000_1037, 32'h8000_0013);
        test_rdreg;
        test_wrmem;
        test_rdmem_backpressure;
        test_abort;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
